// File: rtl/usb_system_sysid_pkg.sv
// usb_system_sysid_pkg: shared state encoding and constants for the sysid boot checker
package usb_system_sysid_pkg;
  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN} state_t;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam int TIMEOUT_W = 8;
endpackage

// File: rtl/usb_system_sysid_checker_if.sv
// usb_system_sysid_checker_if: Avalon-MM read-only bus between the checker and the sysid slave
interface usb_system_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  modport master (output avm_address, avm_read, input avm_waitrequest, avm_readdata);
  modport slave (input avm_address, avm_read, output avm_waitrequest, avm_readdata);
endinterface

// File: rtl/usb_system_avm_read_timer.sv
// usb_system_avm_read_timer: waitrequest stall timeout counter and read-latency down-counter
module usb_system_avm_read_timer import usb_system_sysid_pkg::*; #(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_en,
  input  logic lat_load,
  input  logic lat_en,
  output logic stall_expired,
  output logic lat_expired
);
  localparam logic [1:0] LAT_INIT = READ_LATENCY > 0 ? 2'(READ_LATENCY - 1) : 2'd0;
  logic [TIMEOUT_W-1:0] stall_q, stall_d;
  logic [1:0] lat_q, lat_d;
  // The stall count self-clears on any non-stalled cycle, so each read starts from zero.
  always_comb begin
    stall_d = stall_en ? stall_q + 1'b1 : '0;
    lat_d = lat_load ? LAT_INIT : (lat_en && lat_q != '0) ? lat_q - 1'b1 : lat_q;
  end
  assign stall_expired = stall_en && stall_d == TIMEOUT_W'(TIMEOUT_CYCLES);
  assign lat_expired = lat_q == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_q <= '0;
      lat_q <= '0;
    end else begin
      stall_q <= stall_d;
      lat_q <= lat_d;
    end
endmodule

// File: rtl/usb_system_sysid_checker.sv
// usb_system_sysid_checker: boot-time reader of the sysid ID/timestamp words with match, mismatch and timeout reporting
module usb_system_sysid_checker import usb_system_sysid_pkg::*; #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  usb_system_sysid_checker_if.master   avm,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout_err,
  output logic [31:0]                  sysid_value,
  output logic [31:0]                  timestamp_value
);
  state_t state_q, state_d;
  logic pending_q, pending_d, read_q, read_d, addr_q, addr_d, busy_q, busy_d, done_q, done_d;
  logic pass_q, pass_d, to_q, to_d, id_match_q, id_match_d, ts_match_q, ts_match_d;
  logic [31:0] id_q, id_d, ts_q, ts_d;
  logic rd_st, wr, cap_id, cap_ts, stall_expired, lat_expired;
  assign rd_st = state_q == RD_ID || state_q == RD_TS;
  assign wr = avm.avm_waitrequest;
  usb_system_avm_read_timer #(.READ_LATENCY(READ_LATENCY), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clock), .rst(reset), .stall_en(rd_st && wr), .lat_load(rd_st && !wr),
    .lat_en(state_q == LAT_ID || state_q == LAT_TS),
    .stall_expired(stall_expired), .lat_expired(lat_expired)
  );
  always_comb begin
    state_d = state_q;
    pending_d = pending_q;
    pass_d = pass_q;
    to_d = to_q;
    done_d = 1'b0;
    cap_id = 1'b0;
    cap_ts = 1'b0;
    case (state_q)
      IDLE: if (pending_q || start) begin
        state_d = RD_ID;
        pending_d = 1'b0;
        pass_d = 1'b0;
        to_d = 1'b0;
      end
      RD_ID: if (stall_expired) begin
        state_d = FIN;
        to_d = 1'b1;
      end else if (!wr) begin
        cap_id = READ_LATENCY == 0;
        state_d = READ_LATENCY == 0 ? RD_TS : LAT_ID;
      end
      LAT_ID: if (lat_expired) begin
        cap_id = 1'b1;
        state_d = RD_TS;
      end
      RD_TS: if (stall_expired) begin
        state_d = FIN;
        to_d = 1'b1;
      end else if (!wr) begin
        cap_ts = READ_LATENCY == 0;
        state_d = READ_LATENCY == 0 ? FIN : LAT_TS;
      end
      LAT_TS: if (lat_expired) begin
        cap_ts = 1'b1;
        state_d = FIN;
      end
      FIN: begin
        done_d = 1'b1;
        pass_d = !to_q && id_match_q && (!CHECK_TS || ts_match_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Bus strobes follow the next state so they are flop outputs aligned with RD_x.
    read_d = state_d == RD_ID || state_d == RD_TS;
    addr_d = state_d == RD_TS ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    busy_d = state_d != IDLE;
    id_d = cap_id ? avm.avm_readdata : id_q;
    ts_d = cap_ts ? avm.avm_readdata : ts_q;
    id_match_d = cap_id ? avm.avm_readdata == EXPECTED_ID : id_match_q;
    ts_match_d = cap_ts ? avm.avm_readdata == EXPECTED_TS : ts_match_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      pending_q <= AUTO_START;
      read_q <= 1'b0;
      addr_q <= SYSID_ADDR_ID;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      to_q <= 1'b0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      id_q <= '0;
      ts_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      read_q <= read_d;
      addr_q <= addr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      to_q <= to_d;
      id_match_q <= id_match_d;
      ts_match_q <= ts_match_d;
      id_q <= id_d;
      ts_q <= ts_d;
    end
  assign avm.avm_read = read_q;
  assign avm.avm_address = addr_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign timeout_err = to_q;
  assign sysid_value = id_q;
  assign timestamp_value = ts_q;
endmodule

// File: tb/tb_usb_system_sysid_checker.sv
// tb_usb_system_sysid_checker: scoreboard and vector-table bench for the sysid boot checker
module tb_usb_system_sysid_checker;
  localparam logic [31:0] TS_WORD = 32'h554A_3E34;
  localparam logic [31:0] ID2 = 32'h1234_5678;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1, start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b1;
  logic [31:0] id0 = 32'h0, ts0 = TS_WORD, p1, p2;
  logic busy0, done0, pass0, to0, busy1, done1, pass1, to1, busy2, done2, pass2, to2;
  logic [31:0] sid0, tsv0, sid1, tsv1, sid2, tsv2;
  usb_system_sysid_checker_if b0 ();
  usb_system_sysid_checker_if b1 ();
  usb_system_sysid_checker_if b2 ();
  assign b0.avm_waitrequest = wr0;
  assign b0.avm_readdata = b0.avm_address ? ts0 : id0;
  assign b1.avm_waitrequest = wr1;
  assign b1.avm_readdata = b1.avm_address ? TS_WORD : 32'h0;
  assign b2.avm_waitrequest = wr2;
  assign b2.avm_readdata = p2;
  // Two-stage slave pipeline: data is only valid exactly two cycles after acceptance.
  always @(posedge clk) begin
    p1 <= (b2.avm_read && !wr2) ? (b2.avm_address ? TS_WORD : ID2) : 32'hDEAD_BEEF;
    p2 <= p1;
  end
  usb_system_sysid_checker #(.EXPECTED_ID(32'h0), .EXPECTED_TS(TS_WORD), .CHECK_TS(1'b1),
    .READ_LATENCY(0), .TIMEOUT_CYCLES(16), .AUTO_START(1'b1)) u0 (
    .clock(clk), .reset(rst0), .start(start0), .avm(b0), .busy(busy0), .done(done0),
    .pass(pass0), .timeout_err(to0), .sysid_value(sid0), .timestamp_value(tsv0));
  usb_system_sysid_checker #(.EXPECTED_ID(32'h0), .EXPECTED_TS(32'h1), .CHECK_TS(1'b0),
    .READ_LATENCY(0), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)) u1 (
    .clock(clk), .reset(rst1), .start(start1), .avm(b1), .busy(busy1), .done(done1),
    .pass(pass1), .timeout_err(to1), .sysid_value(sid1), .timestamp_value(tsv1));
  usb_system_sysid_checker #(.EXPECTED_ID(ID2), .EXPECTED_TS(TS_WORD), .CHECK_TS(1'b1),
    .READ_LATENCY(2), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)) u2 (
    .clock(clk), .reset(rst2), .start(start2), .avm(b2), .busy(busy2), .done(done2),
    .pass(pass2), .timeout_err(to2), .sysid_value(sid2), .timestamp_value(tsv2));
  int n_chk = 0, n_fail = 0, n, rc;
  typedef struct {logic pass; logic to; logic [31:0] id; logic [31:0] ts;} res_t;
  typedef struct {logic [31:0] id; logic [31:0] ts; logic pass;} vec_t;
  res_t sb[$];
  res_t e;
  vec_t vt[6];
  logic [31:0] lid = 32'h0, lts = 32'h0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic expect0(input logic p, input logic t);
    if (!t) begin
      lid = id0;
      lts = ts0;
    end
    sb.push_back('{p, t, lid, lts});
  endtask
  task automatic run0(input int exp_n, input string name);
    int k;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    k = 1;
    while (!done0 && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
    chk(name, k, exp_n);
  endtask
  always @(negedge clk)
    if (done0) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 while no check was started");
      end else begin
        e = sb.pop_front();
        chk("sb_pass", pass0, e.pass);
        chk("sb_timeout", to0, e.to);
        chk("sb_sysid", sid0, e.id);
        chk("sb_timestamp", tsv0, e.ts);
      end
    end
  initial begin
    vt[0] = '{32'h0, TS_WORD, 1'b1};
    vt[1] = '{32'h0, 32'h0, 1'b0};
    vt[2] = '{32'h1, TS_WORD, 1'b0};
    vt[3] = '{32'hFFFF_FFFF, 32'h1, 1'b0};
    vt[4] = '{32'h0, 32'h554A_3E35, 1'b0};
    vt[5] = '{32'h0, TS_WORD, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_timeout", to0, 0);
    chk("rst_sysid", sid0, 0);
    chk("rst_ts", tsv0, 0);
    chk("rst_read", b0.avm_read, 0);
    expect0(1'b1, 1'b0);
    @(negedge clk) rst0 = 1'b0;
    n = 0;
    while (!done0 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("auto_start_latency", n, 4);
    chk("auto_timestamp", tsv0, TS_WORD);
    for (int i = 0; i < 6; i++) begin
      id0 = vt[i].id;
      ts0 = vt[i].ts;
      expect0(vt[i].pass, 1'b0);
      run0(4, "table_latency");
      @(posedge clk);
      #1;
    end
    wr0 = 1'b1;
    id0 = 32'hAAAA_AAAA;
    expect0(1'b0, 1'b1);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    n = 1;
    chk("start_clears_pass", pass0, 0);
    rc = b0.avm_read ? 1 : 0;
    while (!done0 && n < 100) begin
      @(posedge clk);
      #1 n++;
      if (b0.avm_read) rc++;
    end
    chk("timeout_latency", n, 18);
    chk("timeout_read_cycles", rc, 16);
    chk("timeout_read_low", b0.avm_read, 0);
    wr0 = 1'b0;
    id0 = 32'h0;
    ts0 = TS_WORD;
    @(posedge clk);
    #1 expect0(1'b1, 1'b0);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    chk("start_clears_timeout", to0, 0);
    @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk);
    #1 chk("fin_busy", busy0, 1);
    @(posedge clk);
    #1 start0 = 1'b0;
    chk("fin_done", done0, 1);
    repeat (10) @(posedge clk);
    #1 chk("no_requeue_busy", busy0, 0);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    @(posedge clk);
    #1 chk("rd_ts_read", b0.avm_read, 1);
    chk("rd_ts_addr", b0.avm_address, 1);
    #2 rst0 = 1'b1;
    #1 chk("async_rst_read", b0.avm_read, 0);
    chk("async_rst_busy", busy0, 0);
    chk("async_rst_pass", pass0, 0);
    chk("async_rst_sysid", sid0, 0);
    chk("async_rst_ts", tsv0, 0);
    expect0(1'b1, 1'b0);
    @(negedge clk) rst0 = 1'b0;
    n = 0;
    while (!done0 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("rerun_latency", n, 4);
    @(negedge clk) rst1 = 1'b0;
    n = 0;
    while (!done1 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("nocheck_ts_latency", n, 4);
    chk("nocheck_ts_pass", pass1, 1);
    chk("nocheck_ts_timeout", to1, 0);
    chk("nocheck_ts_value", tsv1, TS_WORD);
    @(negedge clk) rst2 = 1'b0;
    n = 0;
    rc = 0;
    while (!done2 && n < 100) begin
      @(posedge clk);
      #1 n++;
      if (b2.avm_read) rc++;
      if (n == 6) wr2 = 1'b0;
      if (n == 8) chk("lat_before_capture", sid2, 0);
      if (n == 9) chk("lat_capture", sid2, ID2);
    end
    chk("lat_stall_latency", n, 13);
    chk("lat_read_cycles", rc, 7);
    chk("lat_pass", pass2, 1);
    chk("lat_timeout", to2, 0);
    chk("lat_timestamp", tsv2, TS_WORD);
    repeat (3) @(posedge clk);
    #1 chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
